dense_layer_ctrl: RTL

//  Sequencer for one dense layer of neuron instances that share a clock.
//  - Streams trained weights into each neuron's weight memory over a valid/ready port.
//  - Runs a layer evaluation: clears the accumulators, holds the inputs for the MAC

---
 rtl/dense_layer_ctrl_if.sv | 20 ++
 rtl/dense_layer_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/dense_layer_ctrl_if.sv
// Weight-stream valid/ready channel feeding the dense layer sequencer.
interface dense_layer_ctrl_if #(
  parameter int DW = 16
);
  logic          wt_valid;
  logic          wt_ready;
  logic [DW-1:0] wt_data;

  modport master (
    output wt_valid,
    output wt_data,
    input  wt_ready
  );

  modport slave (
    input  wt_valid,
    input  wt_data,
    output wt_ready
  );
endinterface

// File: rtl/dense_layer_ctrl.sv
// Dense layer sequencer: streams weights into the neurons and
// runs clear / accumulate / drain / done for one evaluation.
module dense_layer_ctrl #(
  parameter int IP_DATA_WIDTH = 8,
  parameter int NUM_IP        = 8,
  parameter int NUM_NEURONS   = 2,
  parameter int MAC_LAT       = 1,
  parameter int ACT_LAT       = 1,
  localparam int IW = $clog2(NUM_IP),
  localparam int WD = 2 * IP_DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_req,
  dense_layer_ctrl_if.slave      wt,
  input  logic                   start,
  output logic                   busy,
  output logic                   wts_loaded,
  output logic [NUM_NEURONS-1:0] neu_wt_sel,
  output logic [IW-1:0]          neu_wt_idx,
  output logic [WD-1:0]          neu_wt_data,
  output logic                   neu_clr,
  output logic                   x_hold,
  output logic                   done,
  output logic                   err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_CLEAR = 3'd2;
  localparam logic [2:0] S_ACCUM = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam int NW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int ACC_N = NUM_IP + MAC_LAT;
  localparam int AW    = $clog2(ACC_N + 1);
  localparam int DRW   = (ACT_LAT > 1) ? $clog2(ACT_LAT) : 1;

  localparam logic [AW-1:0]  ACC_LAST = AW'(ACC_N - 1);
  localparam logic [DRW-1:0] DR_LAST  =
    DRW'((ACT_LAT > 0) ? ACT_LAT - 1 : 0);
  localparam logic [IW-1:0]  I_LAST   = IW'(NUM_IP - 1);
  localparam logic [NW-1:0]  N_LAST   = NW'(NUM_NEURONS - 1);
  localparam logic [2:0]     S_POST   =
    (ACT_LAT > 0) ? S_DRAIN : S_DONE;
  localparam logic [NUM_NEURONS-1:0] SEL_ONE = NUM_NEURONS'(1);

  logic [2:0]     state;
  logic [2:0]     nxt;
  logic [NW-1:0]  n_cnt;
  logic [IW-1:0]  i_cnt;
  logic [AW-1:0]  acc_cnt;
  logic [DRW-1:0] dr_cnt;
  logic           fin;
  logic           accept;
  logic           last_word;
  logic           reload;

  assign wt.wt_ready = (state == S_LOAD);
  assign accept      = (state == S_LOAD) && wt.wt_valid;
  assign last_word   = accept && (i_cnt == I_LAST)
                       && (n_cnt == N_LAST);
  assign reload      = (state == S_IDLE) && load_req;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (load_req)
          nxt = S_LOAD;
        else if (start && wts_loaded)
          nxt = S_CLEAR;
      end
      S_LOAD:  if (last_word) nxt = S_IDLE;
      S_CLEAR: nxt = S_ACCUM;
      S_ACCUM: if (acc_cnt == ACC_LAST) nxt = S_POST;
      S_DRAIN: if (dr_cnt == DR_LAST) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      wts_loaded  <= 1'b0;
      neu_wt_sel  <= '0;
      neu_wt_idx  <= '0;
      neu_wt_data <= '0;
      neu_clr     <= 1'b0;
      x_hold      <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      n_cnt       <= '0;
      i_cnt       <= '0;
      acc_cnt     <= '0;
      dr_cnt      <= '0;
      fin         <= 1'b0;
    end else begin
      state   <= nxt;
      busy    <= (nxt != S_IDLE);
      neu_clr <= (nxt == S_CLEAR);
      x_hold  <= (nxt inside {S_CLEAR, S_ACCUM, S_DRAIN});
      done    <= (nxt == S_DONE);
      err     <= (state == S_IDLE) && start
                 && !load_req && !wts_loaded;

      neu_wt_sel <= accept ? (SEL_ONE << n_cnt) : '0;
      if (accept) begin
        neu_wt_idx  <= i_cnt;
        neu_wt_data <= wt.wt_data;
      end

      // loaded flag follows the final strobe by one cycle
      fin <= last_word;
      if (reload)
        wts_loaded <= 1'b0;
      else if (fin)
        wts_loaded <= 1'b1;

      if (reload) begin
        n_cnt <= '0;
        i_cnt <= '0;
      end else if (accept) begin
        if (i_cnt == I_LAST) begin
          i_cnt <= '0;
          n_cnt <= (n_cnt == N_LAST) ? '0 : n_cnt + 1'b1;
        end else begin
          i_cnt <= i_cnt + 1'b1;
        end
      end

      acc_cnt <= (state == S_ACCUM) ? acc_cnt + 1'b1 : '0;
      dr_cnt  <= (state == S_DRAIN) ? dr_cnt + 1'b1 : '0;
    end
  end

endmodule
